// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit.
// Drains EXE/MEM into a req/ack memory access with load/store formatting.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        load_signed,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] load_data,
  output logic        done,
  output logic        misaligned,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] cnt;
  logic [1:0]  sz_q;
  logic [1:0]  lane_q;
  logic        sgn_q;
  logic        err_q;

  logic        mem_op;
  logic        aligned;
  logic        accept;
  logic        timeout_hit;
  logic [3:0]  be_fmt;
  logic [31:0] wdata_fmt;
  logic [31:0] ld_fmt;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign mem_op = in_valid & (mem_read | mem_write);
  assign accept = (state == S_IDLE) & mem_op & aligned;

  // Counter reaches TIMEOUT-1 on the TIMEOUT-th wait cycle.
  assign timeout_hit = (cnt == 16'(TIMEOUT - 1));

  // Alignment, byte enables and store lane replication.
  always_comb begin
    aligned   = 1'b0;
    be_fmt    = 4'b0000;
    wdata_fmt = wdata;
    unique case (1'b1)
      size == 2'b00: begin
        aligned   = 1'b1;
        be_fmt    = 4'b0001 << addr[1:0];
        wdata_fmt = {4{wdata[7:0]}};
      end
      size == 2'b01: begin
        aligned   = ~addr[0];
        be_fmt    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_fmt = {2{wdata[15:0]}};
      end
      size == 2'b10: begin
        aligned   = (addr[1:0] == 2'b00);
        be_fmt    = 4'b1111;
      end
      default: begin
        aligned   = 1'b0;
      end
    endcase
  end

  // Load lane extraction and sign/zero extension.
  always_comb begin
    ld_byte = dmem_rdata[{lane_q, 3'b000} +: 8];
    ld_half = lane_q[1] ? dmem_rdata[31:16]
                        : dmem_rdata[15:0];
    ld_fmt  = dmem_rdata;
    unique case (1'b1)
      sz_q == 2'b00:
        ld_fmt = {{24{sgn_q & ld_byte[7]}}, ld_byte};
      sz_q == 2'b01:
        ld_fmt = {{16{sgn_q & ld_half[15]}}, ld_half};
      default:
        ld_fmt = dmem_rdata;
    endcase
  end

  // Next state, stall and completion pulses.
  always_comb begin
    state_nxt  = state;
    stall      = 1'b0;
    misaligned = 1'b0;
    done       = 1'b0;
    bus_err    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (mem_op) begin
          if (aligned) begin
            stall     = 1'b1;
            state_nxt = S_WAIT;
          end else begin
            misaligned = 1'b1;
          end
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (dmem_ack || timeout_hit)
          state_nxt = S_RESP;
      end
      S_RESP: begin
        done      = ~err_q;
        bus_err   = err_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Request fields, wait counter and load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_be    <= 4'd0;
      dmem_wdata <= 32'd0;
      load_data  <= 32'd0;
      cnt        <= 16'd0;
      sz_q       <= 2'd0;
      lane_q     <= 2'd0;
      sgn_q      <= 1'b0;
      err_q      <= 1'b0;
    end else if (accept) begin
      dmem_req   <= 1'b1;
      dmem_we    <= mem_write;
      dmem_addr  <= {addr[31:2], 2'b00};
      dmem_be    <= be_fmt;
      dmem_wdata <= wdata_fmt;
      cnt        <= 16'd0;
      sz_q       <= size;
      lane_q     <= addr[1:0];
      sgn_q      <= load_signed;
      err_q      <= 1'b0;
    end else if (state == S_WAIT) begin
      if (dmem_ack) begin
        dmem_req <= 1'b0;
        err_q    <= 1'b0;
        if (!dmem_we)
          load_data <= ld_fmt;
      end else if (timeout_hit) begin
        dmem_req <= 1'b0;
        err_q    <= 1'b1;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit.
// Directed cases plus random ops against a behavioural model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        load_signed;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] load_data;
  logic        done;
  logic        misaligned;
  logic        bus_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model_ld = 32'd0;

  localparam int TO = 4;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .mem_read(mem_read),
    .mem_write(mem_write), .size(size),
    .load_signed(load_signed), .addr(addr),
    .wdata(wdata), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .load_data(load_data),
    .done(done), .misaligned(misaligned),
    .bus_err(bus_err)
  );

  function automatic logic [3:0] exp_be(
    input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 4'(1 << a[1:0]);
    if (sz == 2'd1) return a[1] ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wd(
    input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return (d & 32'hFF) * 32'h01010101;
    if (sz == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(
    input logic [1:0] sz, input logic sgn,
    input logic [31:0] a, input logic [31:0] r);
    logic [31:0] v;
    int sh;
    if (sz == 2'd0) begin
      sh = 8 * int'(a[1:0]);
      v = (r >> sh) & 32'hFF;
      if (sgn && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      sh = a[1] ? 16 : 0;
      v = (r >> sh) & 32'hFFFF;
      if (sgn && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else begin
      v = r;
    end
    return v;
  endfunction

  // Present one op and observe the whole handshake.
  // w = ack after w wait cycles, -1 = never ack.
  task automatic run_op(
    input logic rd, input logic wr,
    input logic [1:0] sz, input logic sgn,
    input logic [31:0] a, input logic [31:0] wd,
    input int w, input logic [31:0] rdat,
    output int ns, output int nr,
    output logic od, output logic oe,
    output logic om, output logic owe,
    output logic ost, output logic opo,
    output logic oto,
    output logic [31:0] oa, output logic [31:0] ow,
    output logic [31:0] ol, output logic [3:0] ob);
    int c;
    logic first;
    ns = 0; nr = 0; od = 0; oe = 0; om = 0;
    owe = 0; ost = 1; opo = 0; oto = 0;
    oa = 0; ow = 0; ol = 0; ob = 0;
    first = 1;
    c = 0;
    @(posedge clk); #1;
    in_valid = 1; mem_read = rd; mem_write = wr;
    size = sz; load_signed = sgn;
    addr = a; wdata = wd;
    while (1) begin
      dmem_ack = (w >= 0) && (c == w + 1);
      dmem_rdata = rdat;
      @(negedge clk);
      if (stall) ns++;
      if (dmem_req) begin
        nr++;
        if (first) begin
          oa = dmem_addr; ow = dmem_wdata;
          ob = dmem_be; owe = dmem_we;
          first = 0;
        end else if (oa !== dmem_addr ||
                     ow !== dmem_wdata ||
                     ob !== dmem_be ||
                     owe !== dmem_we) begin
          ost = 0;
        end
      end
      if (done) od = 1;
      if (bus_err) oe = 1;
      if (misaligned) om = 1;
      if (!stall) break;
      c++;
      if (c > 400) begin
        oto = 1;
        break;
      end
      @(posedge clk); #1;
    end
    ol = load_data;
    @(posedge clk); #1;
    in_valid = 0; mem_read = 0; mem_write = 0;
    dmem_ack = 0;
    @(negedge clk);
    opo = dmem_req | done | bus_err | stall;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be,
         dmem_wdata, load_data, stall, done,
         misaligned, bus_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_outs: got req=%b addr=%h ld=%h stall=%b want all 0",
               dmem_req, dmem_addr, load_data, stall);
    end
    #1 rst = 0;
    model_ld = 0;
  endtask

  task automatic test_word_load;
    int ns, nr;
    logic od, oe, om, owe, ost, opo, oto;
    logic [31:0] oa, ow, ol;
    logic [3:0] ob;
    run_op(1, 0, 2'd2, 0, 32'h100, 32'h0, 0,
           32'hDEADBEEF, ns, nr, od, oe, om, owe,
           ost, opo, oto, oa, ow, ol, ob);
    model_ld = 32'hDEADBEEF;
    n_cmp++;
    if (ns !== 2 || nr !== 1) begin
      n_bad++;
      $display("FAIL word_cycles: got stall=%0d req=%0d want 2/1", ns, nr);
    end
    n_cmp++;
    if (oa !== 32'h100 || ob !== 4'hF || owe !== 0) begin
      n_bad++;
      $display("FAIL word_req: got addr=%h be=%h we=%b want 100/f/0",
               oa, ob, owe);
    end
    n_cmp++;
    if (od !== 1 || oe !== 0 || om !== 0) begin
      n_bad++;
      $display("FAIL word_pulses: got done=%b err=%b mis=%b want 1/0/0",
               od, oe, om);
    end
    n_cmp++;
    if (ol !== model_ld) begin
      n_bad++;
      $display("FAIL word_data: got %h want %h", ol, model_ld);
    end
  endtask

  task automatic test_byte_load;
    int ns, nr;
    logic od, oe, om, owe, ost, opo, oto;
    logic [31:0] oa, ow, ol;
    logic [3:0] ob;
    for (int s = 1; s >= 0; s--) begin
      run_op(1, 0, 2'd0, s[0], 32'h103, 32'h0, 3,
             32'h80123456, ns, nr, od, oe, om, owe,
             ost, opo, oto, oa, ow, ol, ob);
      model_ld = s ? 32'hFFFFFF80 : 32'h00000080;
      n_cmp++;
      if (ns !== 5 || ob !== 4'h8 || od !== 1) begin
        n_bad++;
        $display("FAIL byte_ctl: got stall=%0d be=%h done=%b want 5/8/1",
                 ns, ob, od);
      end
      n_cmp++;
      if (ol !== model_ld) begin
        n_bad++;
        $display("FAIL byte_data s=%0d: got %h want %h", s, ol, model_ld);
      end
      n_cmp++;
      if (ost !== 1 || oa !== 32'h100) begin
        n_bad++;
        $display("FAIL byte_fields: got stable=%b addr=%h want 1/100",
                 ost, oa);
      end
    end
  endtask

  task automatic test_half_store;
    int ns, nr;
    logic od, oe, om, owe, ost, opo, oto;
    logic [31:0] oa, ow, ol;
    logic [3:0] ob;
    run_op(0, 1, 2'd1, 0, 32'h22, 32'h0000ABCD, 0,
           32'h13572468, ns, nr, od, oe, om, owe,
           ost, opo, oto, oa, ow, ol, ob);
    n_cmp++;
    if (owe !== 1 || ob !== 4'hC || ow !== 32'hABCDABCD) begin
      n_bad++;
      $display("FAIL hstore_req: got we=%b be=%h wd=%h want 1/c/abcdabcd",
               owe, ob, ow);
    end
    n_cmp++;
    if (ol !== model_ld || od !== 1) begin
      n_bad++;
      $display("FAIL hstore_ld: got ld=%h done=%b want %h/1",
               ol, od, model_ld);
    end
  endtask

  task automatic test_misaligned;
    int ns, nr;
    logic od, oe, om, owe, ost, opo, oto;
    logic [31:0] oa, ow, ol;
    logic [3:0] ob;
    logic [1:0] szs [2];
    logic [31:0] as [2];
    szs[0] = 2'd2; as[0] = 32'h101;
    szs[1] = 2'd3; as[1] = 32'h100;
    for (int i = 0; i < 2; i++) begin
      run_op(1, 0, szs[i], 0, as[i], 32'h0, 0,
             32'hFFFFFFFF, ns, nr, od, oe, om, owe,
             ost, opo, oto, oa, ow, ol, ob);
      n_cmp++;
      if (om !== 1 || ns !== 0 || nr !== 0 ||
          od !== 0 || opo !== 0) begin
        n_bad++;
        $display("FAIL misal_%0d: got mis=%b stall=%0d req=%0d done=%b post=%b want 1/0/0/0/0",
                 i, om, ns, nr, od, opo);
      end
      n_cmp++;
      if (ol !== model_ld) begin
        n_bad++;
        $display("FAIL misal_ld_%0d: got %h want %h", i, ol, model_ld);
      end
    end
  endtask

  task automatic test_timeout;
    int ns, nr;
    logic od, oe, om, owe, ost, opo, oto;
    logic [31:0] oa, ow, ol;
    logic [3:0] ob;
    logic seen;
    run_op(1, 0, 2'd2, 0, 32'h40, 32'h0, -1,
           32'h12345678, ns, nr, od, oe, om, owe,
           ost, opo, oto, oa, ow, ol, ob);
    n_cmp++;
    if (nr !== TO || ns !== TO + 1 || oto !== 0) begin
      n_bad++;
      $display("FAIL tmo_cycles: got req=%0d stall=%0d want %0d/%0d",
               nr, ns, TO, TO + 1);
    end
    n_cmp++;
    if (oe !== 1 || od !== 0 || ol !== model_ld) begin
      n_bad++;
      $display("FAIL tmo_resp: got err=%b done=%b ld=%h want 1/0/%h",
               oe, od, ol, model_ld);
    end
    seen = 0;
    @(posedge clk); #1;
    dmem_ack = 1;
    dmem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    seen = done | dmem_req | stall;
    @(posedge clk); #1;
    dmem_ack = 0;
    @(negedge clk);
    seen = seen | done | dmem_req | bus_err;
    n_cmp++;
    if (seen !== 0 || load_data !== model_ld) begin
      n_bad++;
      $display("FAIL tmo_late_ack: got act=%b ld=%h want 0/%h",
               seen, load_data, model_ld);
    end
  endtask

  task automatic test_reset_in_wait;
    logic seen;
    @(posedge clk); #1;
    in_valid = 1; mem_read = 1; mem_write = 0;
    size = 2'd2; load_signed = 0;
    addr = 32'h200; wdata = 32'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (dmem_req !== 1 || stall !== 1) begin
      n_bad++;
      $display("FAIL rstw_pre: got req=%b stall=%b want 1/1",
               dmem_req, stall);
    end
    #1 rst = 1;
    in_valid = 0; mem_read = 0;
    @(posedge clk); #1;
    rst = 0;
    model_ld = 0;
    @(negedge clk);
    n_cmp++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be,
         dmem_wdata, load_data, stall, done,
         misaligned, bus_err} !== '0) begin
      n_bad++;
      $display("FAIL rstw_outs: got req=%b addr=%h be=%h ld=%h stall=%b want all 0",
               dmem_req, dmem_addr, dmem_be, load_data, stall);
    end
    @(posedge clk); #1;
    dmem_ack = 1;
    dmem_rdata = 32'h55AA55AA;
    @(negedge clk);
    seen = done | dmem_req;
    @(posedge clk); #1;
    dmem_ack = 0;
    @(negedge clk);
    seen = seen | done | dmem_req | bus_err;
    n_cmp++;
    if (seen !== 0 || load_data !== 32'd0) begin
      n_bad++;
      $display("FAIL rstw_ack: got act=%b ld=%h want 0/0",
               seen, load_data);
    end
  endtask

  task automatic test_random;
    int ns, nr;
    logic od, oe, om, owe, ost, opo, oto;
    logic [31:0] oa, ow, ol;
    logic [3:0] ob;
    logic rd, wr, sgn, mem, ok;
    logic [1:0] sz;
    logic [31:0] a, wd, rdat;
    int w, ens, enr;
    logic [2:0] epul;
    for (int i = 0; i < 40; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sgn = 1'($urandom_range(0, 1));
      a = $urandom;
      if ($urandom_range(0, 3) != 0)
        a = a & ~((sz == 2'd0) ? 32'd0 :
                  (sz == 2'd1) ? 32'd1 : 32'd3);
      wd = $urandom;
      rdat = $urandom;
      w = $urandom_range(0, 4);
      if (w == 4) w = -1;
      run_op(rd, wr, sz, sgn, a, wd, w, rdat,
             ns, nr, od, oe, om, owe,
             ost, opo, oto, oa, ow, ol, ob);
      mem = rd | wr;
      ok = (sz == 2'd0) ||
           (sz == 2'd1 && a % 2 == 0) ||
           (sz == 2'd2 && a % 4 == 0);
      if (!mem) begin
        ens = 0; enr = 0; epul = 3'b000;
      end else if (!ok) begin
        ens = 0; enr = 0; epul = 3'b001;
      end else begin
        enr = (w >= 0) ? w + 1 : TO;
        ens = enr + 1;
        epul = (w >= 0) ? 3'b100 : 3'b010;
        if (!wr && w >= 0)
          model_ld = exp_load(sz, sgn, a, rdat);
      end
      n_cmp++;
      if (ns !== ens || nr !== enr || oto !== 0) begin
        n_bad++;
        $display("FAIL rnd%0d_cycles: got stall=%0d req=%0d want %0d/%0d",
                 i, ns, nr, ens, enr);
      end
      n_cmp++;
      if ({od, oe, om} !== epul) begin
        n_bad++;
        $display("FAIL rnd%0d_pulses: got %b want %b",
                 i, {od, oe, om}, epul);
      end
      n_cmp++;
      if (ol !== model_ld || opo !== 0) begin
        n_bad++;
        $display("FAIL rnd%0d_ld: got %h post=%b want %h/0",
                 i, ol, opo, model_ld);
      end
      if (mem && ok) begin
        n_cmp++;
        if (oa !== (a & ~32'd3) || ob !== exp_be(sz, a) ||
            owe !== wr || ost !== 1) begin
          n_bad++;
          $display("FAIL rnd%0d_req: got addr=%h be=%h we=%b st=%b want %h/%h/%b/1",
                   i, oa, ob, owe, ost, a & ~32'd3,
                   exp_be(sz, a), wr);
        end
        if (wr) begin
          n_cmp++;
          if (ow !== exp_wd(sz, wd)) begin
            n_bad++;
            $display("FAIL rnd%0d_wdata: got %h want %h",
                     i, ow, exp_wd(sz, wd));
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1; in_valid = 0; mem_read = 0;
    mem_write = 0; size = 0; load_signed = 0;
    addr = 0; wdata = 0; dmem_ack = 0;
    dmem_rdata = 0;
    test_reset;
    test_word_load;
    test_byte_load;
    test_half_store;
    test_misaligned;
    test_timeout;
    test_reset_in_wait;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
